// File: rtl/l15_req_arbiter_if.sv
// Request/response bundle between the two requesters (IM, DM), the arbiter and the L1.5.
//   slave  : arbiter side (takes requests and L1.5 responses, drives acks and the L1.5 request)
//   master : environment side (requesters + L1.5 model)
// Signals:
//   im_*/dm_*        requester request fields, val, hdr_ack, rsp_val
//   rsp_*            response pass-through shared by both requesters
//   core_l15_*       registered request towards the L1.5, plus response consume ack
//   l15_core_*       L1.5 header ack and response channel
interface l15_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [4:0]        im_rqtype;
    logic [2:0]        im_size;
    logic [ADDR_W-1:0] im_address;
    logic [DATA_W-1:0] im_data;
    logic              im_val;
    logic              im_hdr_ack;
    logic              im_rsp_val;

    logic [4:0]        dm_rqtype;
    logic [2:0]        dm_size;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_data;
    logic              dm_val;
    logic              dm_hdr_ack;
    logic              dm_rsp_val;

    logic [3:0]        rsp_returntype;
    logic [DATA_W-1:0] rsp_data_0;
    logic [DATA_W-1:0] rsp_data_1;

    logic [4:0]        core_l15_rqtype;
    logic [2:0]        core_l15_size;
    logic [ADDR_W-1:0] core_l15_address;
    logic [DATA_W-1:0] core_l15_data;
    logic              core_l15_val;
    logic              core_l15_req_ack;

    logic              l15_core_header_ack;
    logic              l15_core_val;
    logic [3:0]        l15_core_returntype;
    logic [DATA_W-1:0] l15_core_data_0;
    logic [DATA_W-1:0] l15_core_data_1;

    modport slave (
        input  im_rqtype, im_size, im_address, im_data, im_val,
        input  dm_rqtype, dm_size, dm_address, dm_data, dm_val,
        output im_hdr_ack, im_rsp_val, dm_hdr_ack, dm_rsp_val,
        output rsp_returntype, rsp_data_0, rsp_data_1,
        output core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
        output core_l15_val, core_l15_req_ack,
        input  l15_core_header_ack, l15_core_val, l15_core_returntype,
        input  l15_core_data_0, l15_core_data_1
    );

    modport master (
        output im_rqtype, im_size, im_address, im_data, im_val,
        output dm_rqtype, dm_size, dm_address, dm_data, dm_val,
        input  im_hdr_ack, im_rsp_val, dm_hdr_ack, dm_rsp_val,
        input  rsp_returntype, rsp_data_0, rsp_data_1,
        input  core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
        input  core_l15_val, core_l15_req_ack,
        output l15_core_header_ack, l15_core_val, l15_core_returntype,
        output l15_core_data_0, l15_core_data_1
    );
endinterface

// File: rtl/l15_req_arbiter.sv
// Shares the single core-to-L1.5 request channel between instruction fetch (IM, owner 0) and
// data memory (DM, owner 1). One transaction in flight: the winner's fields are latched and
// held on core_l15_* until the L1.5 header ack, then the matching response is routed back.
// Ports:
//   clk        clock, rising edge
//   nrst       asynchronous active-low reset
//   bus        l15_req_arbiter_if.slave (requester, response and L1.5 channels)
//   arb_busy   transaction in progress
//   arb_owner  current/last grant (0 = IM, 1 = DM)
module l15_req_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [3:0]  RT_LOAD    = 4'b0000,
    parameter logic [3:0]  RT_STACK   = 4'b0100
) (
    input  logic                   clk,
    input  logic                   nrst,
    l15_req_arbiter_if.slave       bus,
    output logic                   arb_busy,
    output logic                   arb_owner
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e            state_q, state_d;
    logic [4:0]        rqtype_q, rqtype_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;   // 1 = DM wins the next tie

    logic              grant_dm;
    logic [3:0]        exp_type;
    logic              rsp_match;
    logic              hdr_ack;
    logic              rsp_val;

    always_comb begin
        state_d  = state_q;
        rqtype_d = rqtype_q;
        size_d   = size_q;
        addr_d   = addr_q;
        data_d   = data_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        hdr_ack  = 1'b0;
        rsp_val  = 1'b0;

        if (bus.im_val && bus.dm_val) begin
            grant_dm = FIXED_PRIO ? 1'b1 : prio_q;
        end else begin
            grant_dm = bus.dm_val;
        end

        // Stores complete with RT_STACK; every other request type completes with RT_LOAD.
        exp_type  = (rqtype_q == 5'd1) ? RT_STACK : RT_LOAD;
        rsp_match = bus.l15_core_val && (bus.l15_core_returntype == exp_type);

        unique case (state_q)
            StIdle: begin
                if (bus.im_val || bus.dm_val) begin
                    owner_d  = grant_dm;
                    rqtype_d = grant_dm ? bus.dm_rqtype  : bus.im_rqtype;
                    size_d   = grant_dm ? bus.dm_size    : bus.im_size;
                    addr_d   = grant_dm ? bus.dm_address : bus.im_address;
                    data_d   = grant_dm ? bus.dm_data    : bus.im_data;
                    if (!FIXED_PRIO) begin
                        prio_d = ~grant_dm;
                    end
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (bus.l15_core_header_ack) begin
                    hdr_ack = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_match) begin
                    rsp_val = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            rqtype_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            rqtype_q <= rqtype_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
        end
    end

    assign bus.core_l15_rqtype  = rqtype_q;
    assign bus.core_l15_size    = size_q;
    assign bus.core_l15_address = addr_q;
    assign bus.core_l15_data    = data_q;
    assign bus.core_l15_val     = (state_q == StReq);

    // Every response is consumed; unexpected ones are simply not forwarded.
    // Gated by nrst so nothing is acknowledged while reset is held.
    assign bus.core_l15_req_ack = bus.l15_core_val & nrst;

    assign bus.im_hdr_ack = hdr_ack & ~owner_q;
    assign bus.dm_hdr_ack = hdr_ack &  owner_q;
    assign bus.im_rsp_val = rsp_val & ~owner_q;
    assign bus.dm_rsp_val = rsp_val &  owner_q;

    assign bus.rsp_returntype = bus.l15_core_returntype;
    assign bus.rsp_data_0     = bus.l15_core_data_0;
    assign bus.rsp_data_1     = bus.l15_core_data_1;

    assign arb_busy  = (state_q != StIdle);
    assign arb_owner = owner_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Randomized bench for l15_req_arbiter. The reference model tracks pending requests per
// requester and the grant history; the tie winner follows from the number of grants so far.
module tb_l15_req_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam bit          FIXED_PRIO = 1'b0;

    logic clk = 1'b0;
    logic nrst;
    logic arb_busy;
    logic arb_owner;

    always #5 clk = ~clk;

    l15_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    l15_req_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIXED_PRIO (FIXED_PRIO),
        .RT_LOAD    (4'b0000),
        .RT_STACK   (4'b0100)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus),
        .arb_busy  (arb_busy),
        .arb_owner (arb_owner)
    );

    // Reference model: pending request per requester (0 = IM, 1 = DM) and grant history.
    bit          p_val [2];
    logic [4:0]  p_rq  [2];
    logic [2:0]  p_sz  [2];
    logic [31:0] p_ad  [2];
    logic [63:0] p_da  [2];
    int          n_grants;
    bit          last_win;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic new_req(input int who, input logic [4:0] rq, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [63:0] da);
        p_val[who] = 1'b1;
        p_rq[who]  = rq;
        p_sz[who]  = sz;
        p_ad[who]  = ad;
        p_da[who]  = da;
    endtask

    task automatic rand_req(input int who);
        logic [4:0] rq;
        case ($urandom_range(0, 3))
            0:       rq = 5'd0;
            1:       rq = 5'd1;
            default: rq = 5'($urandom);
        endcase
        new_req(who, rq, 3'($urandom), $urandom, {$urandom, $urandom});
    endtask

    task automatic drive_req();
        bus.im_val     = p_val[0];
        bus.im_rqtype  = p_rq[0];
        bus.im_size    = p_sz[0];
        bus.im_address = p_ad[0];
        bus.im_data    = p_da[0];
        bus.dm_val     = p_val[1];
        bus.dm_rqtype  = p_rq[1];
        bus.dm_size    = p_sz[1];
        bus.dm_address = p_ad[1];
        bus.dm_data    = p_da[1];
    endtask

    // Round-robin: DM first after reset, then whoever did not win the previous grant.
    function automatic bit exp_winner();
        if (p_val[0] && p_val[1]) begin
            if (FIXED_PRIO) return 1'b1;
            return (n_grants == 0) ? 1'b1 : ~last_win;
        end
        return p_val[1];
    endfunction

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic run_txn(input int hdr_dly, input int rsp_dly, input bit mutate);
        bit          w;
        bit          hack;
        bit          rv;
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [63:0] da;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [3:0]  et;
        logic [3:0]  bt;

        drive_req();
        bus.l15_core_header_ack = 1'b0;
        bus.l15_core_val        = 1'b0;
        #1;
        check_eq("idle_busy", arb_busy, 0);
        check_eq("idle_core_val", bus.core_l15_val, 0);

        w  = exp_winner();
        rq = p_rq[w];
        sz = p_sz[w];
        ad = p_ad[w];
        da = p_da[w];
        et = (rq == 5'd1) ? 4'b0100 : 4'b0000;
        n_grants++;
        last_win = w;

        @(negedge clk);
        for (int i = 0; i <= hdr_dly; i++) begin
            if (mutate) begin
                if (w) begin
                    bus.dm_address = $urandom;
                    bus.dm_data    = {$urandom, $urandom};
                end else begin
                    bus.im_address = $urandom;
                    bus.im_rqtype  = 5'($urandom);
                end
            end
            hack = (i == hdr_dly);
            rv   = ($urandom_range(0, 3) == 0);
            bus.l15_core_header_ack = hack;
            bus.l15_core_val        = rv;
            bus.l15_core_returntype = et;
            bus.l15_core_data_0     = {$urandom, $urandom};
            bus.l15_core_data_1     = {$urandom, $urandom};
            #1;
            check_eq("req_core_val", bus.core_l15_val, 1);
            check_eq("req_rqtype", bus.core_l15_rqtype, rq);
            check_eq("req_size", bus.core_l15_size, sz);
            check_eq("req_address", bus.core_l15_address, ad);
            check_eq("req_data", bus.core_l15_data, da);
            check_eq("req_owner", arb_owner, w);
            check_eq("req_busy", arb_busy, 1);
            check_eq("im_hdr_ack", bus.im_hdr_ack, hack && !w);
            check_eq("dm_hdr_ack", bus.dm_hdr_ack, hack && w);
            check_eq("req_stray_ack", bus.core_l15_req_ack, rv);
            check_eq("req_rsp_vals", {bus.im_rsp_val, bus.dm_rsp_val}, 0);
            @(negedge clk);
        end

        p_val[w] = 1'b0;
        drive_req();
        bus.l15_core_header_ack = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            if (i == rsp_dly) begin
                rv = 1'b1;
                bt = et;
            end else begin
                rv = 1'($urandom_range(0, 1));
                do bt = 4'($urandom_range(0, 15)); while (bt == et);
            end
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            bus.l15_core_val        = rv;
            bus.l15_core_returntype = bt;
            bus.l15_core_data_0     = d0;
            bus.l15_core_data_1     = d1;
            #1;
            check_eq("resp_core_val", bus.core_l15_val, 0);
            check_eq("resp_busy", arb_busy, 1);
            check_eq("resp_hdr_acks", {bus.im_hdr_ack, bus.dm_hdr_ack}, 0);
            check_eq("im_rsp_val", bus.im_rsp_val, (i == rsp_dly) && !w);
            check_eq("dm_rsp_val", bus.dm_rsp_val, (i == rsp_dly) && w);
            check_eq("resp_req_ack", bus.core_l15_req_ack, rv);
            if (i == rsp_dly) begin
                check_eq("rsp_type", bus.rsp_returntype, et);
                check_eq("rsp_data_0", bus.rsp_data_0, d0);
                check_eq("rsp_data_1", bus.rsp_data_1, d1);
            end
            @(negedge clk);
        end
        bus.l15_core_val = 1'b0;
        #1;
        check_eq("done_busy", arb_busy, 0);
    endtask

    task automatic idle_unsolicited();
        drive_req();
        bus.l15_core_val        = 1'b1;
        bus.l15_core_returntype = 4'b0011;
        #1;
        check_eq("unsol_ack", bus.core_l15_req_ack, 1);
        check_eq("unsol_rsp", {bus.im_rsp_val, bus.dm_rsp_val}, 0);
        @(negedge clk);
        bus.l15_core_val = 1'b0;
        #1;
        check_eq("unsol_busy", arb_busy, 0);
        check_eq("unsol_core_val", bus.core_l15_val, 0);
    endtask

    task automatic reset_in_resp();
        new_req(1, 5'd0, 3'd3, 32'h0000_3000, 64'h0);
        drive_req();
        @(negedge clk);
        bus.l15_core_header_ack = 1'b1;
        @(negedge clk);
        bus.l15_core_header_ack = 1'b0;
        p_val[1] = 1'b0;
        drive_req();
        bus.l15_core_val        = 1'b1;
        bus.l15_core_returntype = 4'b0000;
        #1;
        check_eq("pre_rst_busy", arb_busy, 1);
        nrst = 1'b0;
        #1;
        check_eq("rst_rsp_vals", {bus.im_rsp_val, bus.dm_rsp_val}, 0);
        check_eq("rst_hdr_acks", {bus.im_hdr_ack, bus.dm_hdr_ack}, 0);
        check_eq("rst_req_ack", bus.core_l15_req_ack, 0);
        check_eq("rst_core_val", bus.core_l15_val, 0);
        check_eq("rst_address", bus.core_l15_address, 0);
        check_eq("rst_busy", arb_busy, 0);
        check_eq("rst_owner", arb_owner, 0);
        @(negedge clk);
        bus.l15_core_val = 1'b0;
        nrst = 1'b1;
        n_grants = 0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        n_grants = 0;
        last_win = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_val[i] = 1'b0;
            p_rq[i]  = '0;
            p_sz[i]  = '0;
            p_ad[i]  = '0;
            p_da[i]  = '0;
        end
        drive_req();
        bus.l15_core_header_ack = 1'b0;
        bus.l15_core_val        = 1'b0;
        bus.l15_core_returntype = '0;
        bus.l15_core_data_0     = '0;
        bus.l15_core_data_1     = '0;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_busy", arb_busy, 0);
        check_eq("reset_owner", arb_owner, 0);
        check_eq("reset_core_val", bus.core_l15_val, 0);
        check_eq("reset_rqtype", bus.core_l15_rqtype, 0);
        check_eq("reset_address", bus.core_l15_address, 0);
        check_eq("reset_data", bus.core_l15_data, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Three back-to-back ties after reset: DM, IM, DM.
        rand_req(0);
        rand_req(1);
        run_txn(1, 1, 1'b0);
        rand_req(1);
        run_txn(0, 2, 1'b0);
        rand_req(0);
        run_txn(2, 0, 1'b0);
        run_txn(0, 0, 1'b0);

        idle_unsolicited();

        // DM load, then DM store with a long header-ack delay.
        new_req(1, 5'd0, 3'd3, 32'h0000_1004, 64'h0);
        run_txn(0, 0, 1'b0);
        new_req(1, 5'd1, 3'd3, 32'h0000_2000, 64'hDEAD_BEEF_DEAD_BEEF);
        run_txn(5, 3, 1'b0);

        // IM request whose fields change while in flight.
        new_req(0, 5'd0, 3'd2, 32'h0000_4000, 64'h0);
        run_txn(3, 1, 1'b1);

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_val[r] && $urandom_range(0, 1) == 1) rand_req(r);
            end
            if (!p_val[0] && !p_val[1]) rand_req(int'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end
        while (p_val[0] || p_val[1]) run_txn(0, 0, 1'b0);

        reset_in_resp();
        new_req(0, 5'd0, 3'd3, 32'h0000_5008, 64'h0);
        run_txn(1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Shares the single core-to-L1.5 request/response channel between two requesters: instruction fetch (IM, index 0) and data memory (DM, index 1, the load/store pipeline).
- Sits between both requester FSMs and the L1.5 boundary.
- One transaction outstanding at a time.
- Registers the granted request and holds it stable until the L1.5 header ack, then routes the matching response back to the owner.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 64, request/response data beat width
- FIXED_PRIO, 0, 0 = round-robin between IM/DM; 1 = DM always wins ties
- RT_LOAD, 4'b0000, returntype that completes a load (rqtype 5'b00000)
- RT_STACK, 4'b0100, returntype that completes a store (rqtype 5'b00001)

Ports:
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- im_rqtype/dm_rqtype  in  5  requester request type
- im_size/dm_size  in  3  requester size code
- im_address/dm_address  in  ADDR_W  requester address
- im_data/dm_data  in  DATA_W  requester store data
- im_val/dm_val  in  1  request valid; held with fields until own hdr_ack
- im_hdr_ack/dm_hdr_ack  out  1  request accepted by L1.5
- im_rsp_val/dm_rsp_val  out  1  one-cycle completion pulse
- rsp_returntype  out  4  pass-through of l15_core_returntype
- rsp_data_0/rsp_data_1  out  DATA_W  pass-through of L1.5 data, shared by both requesters
- core_l15_rqtype  out  5  registered granted rqtype
- core_l15_size  out  3  registered granted size
- core_l15_address  out  ADDR_W  registered granted address
- core_l15_data  out  DATA_W  registered granted data
- core_l15_val  out  1  request valid to L1.5
- l15_core_header_ack  in  1  L1.5 accepted request
- l15_core_val  in  1  response valid
- l15_core_returntype  in  4  response type
- l15_core_data_0/l15_core_data_1  in  DATA_W  response data
- core_l15_req_ack  out  1  response consumed
- arb_busy  out  1  state != IDLE
- arb_owner  out  1  current/last grant (0 = IM, 1 = DM)

Behaviour:
- Reset (async, nrst low, any state including mid-transaction):
  - state = IDLE, all core_l15_* = 0, arb_owner = 0, prio = DM.
  - hdr_acks, rsp_vals and core_l15_req_ack are 0; the in-flight transaction is abandoned.
- States:
  - IDLE: sample im_val/dm_val.
    - One valid: grant it.
    - Both valid: grant the prio side.
    - Latch the winner's fields into core_l15_*, set arb_owner, go to REQ.
    - With FIXED_PRIO=0, prio flips to the non-winner after each grant.
  - REQ: core_l15_val = 1 with latched fields stable.
    - On l15_core_header_ack: owner's hdr_ack = 1 that same cycle (combinational), core_l15_val deasserts next cycle, go to RESP.
  - RESP: expected returntype = RT_LOAD if latched rqtype == 0, RT_STACK if == 1, else RT_LOAD.
    - On l15_core_val with expected type: owner's rsp_val = 1 and core_l15_req_ack = 1 that cycle, go to IDLE.
- Latency:
  - val-to-core_l15_val = 1 cycle.
  - header_ack-to-hdr_ack = 0 cycles.
  - l15_core_val-to-rsp_val = 0 cycles.
  - Minimum issue spacing = 1 IDLE cycle between transactions.
- Responses outside this flow: any l15_core_val in IDLE/REQ, or with a non-matching type in RESP, gets core_l15_req_ack = 1, is dropped (no rsp_val), and causes no state change.
- The non-owner's hdr_ack/rsp_val are always 0. Both rsp_val are never high together.
- A request only needs the sampled val in IDLE; the requester deasserts val or presents a new request after its rsp_val.
- Requester fields changing while in REQ/RESP have no effect (latched copy is used).
- header_ack and l15_core_val in the same REQ cycle: header handled; response treated as not matching (acked, dropped).
- rsp_data/rsp_returntype are pure pass-through and meaningful only with rsp_val.

Test Plan:
- Single DM load, addr 0x0000_1004 → next cycle core_l15_val=1, rqtype=0, address=0x1004; header_ack → dm_hdr_ack same cycle; l15_core_val with type 4'b0000, data_0=0x1122334455667788 → dm_rsp_val=1, rsp_data_0 matches, core_l15_req_ack=1, arb_busy=0 next cycle.
- Simultaneous IM/DM requests after reset, FIXED_PRIO=0 → DM granted first, IM second, DM again on a third tie; the FIXED_PRIO=1 build grants DM on every tie.
- DM store, rqtype=1, data 0xDEADBEEF_DEADBEEF, header_ack delayed 5 cycles → core_l15_* stable for all 5; response type 4'b0000 ignored and acked; type 4'b0100 completes.
- Unsolicited l15_core_val in IDLE (type 4'b0011) → core_l15_req_ack=1, no rsp_val, state stays IDLE.
- nrst asserted in RESP → all outputs 0 immediately, no rsp_val; after release, a new IM request is granted normally.
- IM changes im_address while in REQ → core_l15_address keeps the latched value; only im_* hdr_ack/rsp_val toggle, dm_* stay 0.
